nes_cart_mem_arbiter: RTL and testbench
=======================================

Name: nes_cart_mem_arbiter

Overview:
- Sits directly downstream of the cart mapper modules; consumes the resolved mapper bus (prg/chr address, allow, prg_dout, prg_bus_write flag).
- Turns single-cycle CPU (PRG) and PPU (CHR) access strobes into serialized requests on one shared req/ack memory port (SDRAM controller side).
- Returns read data to each side and serves mapper-driven registers (prg_bus_write) without touching memory.
- One outstanding request per side; CHR has priority, with a starvation bound for PRG.

Parameters:
- ADDR_W, 22, width of mapper and memory addresses
- STARVE_LIMIT, 2, maximum consecutive CHR grants while a PRG request is pending (legal range 1..7)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- prg_read  in  1  one-cycle CPU read strobe (already ce-qualified)
- prg_write  in  1  one-cycle CPU write strobe
- prg_aout  in  ADDR_W  mapper-resolved PRG address
- prg_allow  in  1  mapper permits the PRG memory access
- prg_din  in  8  CPU write data
- prg_bus_write  in  1  mapper drives CPU read data itself (flags_out bit 1)
- map_prg_dout  in  8  mapper-driven read data
- chr_read  in  1  one-cycle PPU read strobe
- chr_write  in  1  one-cycle PPU write strobe
- chr_aout  in  ADDR_W  mapper-resolved CHR address
- chr_allow  in  1  mapper permits a CHR write
- chr_din  in  8  PPU write data
- prg_rdata  out  8  PRG read result
- prg_rvalid  out  1  one-cycle pulse, prg_rdata valid
- chr_rdata  out  8  CHR read result
- chr_rvalid  out  1  one-cycle pulse, chr_rdata valid
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write qualifier for mem_req
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  memory write data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  8  read data, valid with mem_ack
- overflow  out  1  sticky: strobe arrived while the same side was pending

Behaviour:
- Reset values: all outputs 0; pending slots empty; FSM IDLE; starvation counter 0; prg open-bus latch 8'hFF.
- Capture, PRG strobe in cycle N:
  - prg_read with prg_bus_write=1: no memory access. prg_rdata=map_prg_dout and prg_rvalid=1 in N+1; open-bus latch updated.
  - prg_read with prg_allow=0 and prg_bus_write=0: prg_rvalid in N+1 with the open-bus latch value.
  - prg_write with prg_allow=0: dropped silently; no rvalid.
  - Otherwise latch {addr, we, data} into the PRG pending slot at the N edge.
- Capture, CHR strobe:
  - chr_write with chr_allow=0 is dropped.
  - chr_read always goes to memory.
  - Otherwise latch into the CHR pending slot.
- Strobe on a side whose slot is already full (not completing this cycle): strobe dropped, overflow set until reset.
- Slot completing (mem_ack) in the same cycle as a new strobe on that side: ack retires, new request accepted, no overflow.
- FSM IDLE:
  - Either slot full: grant.
  - Grant goes to CHR unless PRG is pending and the starvation counter equals STARVE_LIMIT; then PRG.
  - On grant: mem_req=1 with registered addr/we/wdata from the next cycle, state -> BUSY.
  - Counter: +1 on a CHR grant while PRG is pending; cleared on a PRG grant or when PRG is not pending.
- FSM BUSY:
  - mem_req/mem_addr/mem_we/mem_wdata held stable until mem_ack.
  - On mem_ack: mem_req=0 the next cycle, granted slot freed, state -> IDLE.
  - For reads: {side}_rdata=mem_rdata and {side}_rvalid=1 in the cycle after ack. A PRG read also updates the open-bus latch.
  - Writes produce no rvalid.
- Minimum turnaround: one IDLE cycle between ack and the next mem_req (no back-to-back req).
- mem_ack while IDLE is ignored.
- Reset mid-transaction:
  - mem_req drops the next cycle; slots are cleared; no rvalid is issued.
  - A late ack after reset is ignored.
- prg_read and prg_write together in one cycle: write wins, read ignored. Same rule for chr.
- Both sides strobing in the same cycle: both captured.

Test Plan:
- PRG read 0x008123, allow=1, bus_write=0, mem_ack 3 cycles after mem_req with rdata 8'hA5 -> mem_addr=0x008123, mem_we=0; prg_rvalid pulses once with prg_rdata=8'hA5 the cycle after ack.
- prg_read with prg_bus_write=1, map_prg_dout=8'h3A -> prg_rvalid, prg_rdata=8'h3A next cycle, mem_req stays 0; a following disallowed read returns 8'h3A (open bus).
- Simultaneous PRG read and CHR read in one cycle -> CHR granted first, PRG second; both rvalids in order.
- PRG pending with continuous CHR strobes, STARVE_LIMIT=2 -> grant sequence CHR, CHR, PRG.
- Second chr_read while the CHR slot is busy -> overflow=1 (sticky), exactly one mem_req for CHR.
- chr_write allow=0 -> no mem_req. Reset asserted mid-BUSY -> mem_req=0 next cycle, no rvalid; later ack ignored.

Source files
------------

// File: rtl/nes_cart_mem_arbiter.sv
// Serializes mapper-resolved CPU (PRG) and PPU (CHR) strobes onto one req/ack memory port.
// CHR has priority; a pending PRG request wins after STARVE_LIMIT consecutive CHR grants.
module nes_cart_mem_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prg_read,
  input  logic              prg_write,
  input  logic [ADDR_W-1:0] prg_aout,
  input  logic              prg_allow,
  input  logic [7:0]        prg_din,
  input  logic              prg_bus_write,
  input  logic [7:0]        map_prg_dout,
  input  logic              chr_read,
  input  logic              chr_write,
  input  logic [ADDR_W-1:0] chr_aout,
  input  logic              chr_allow,
  input  logic [7:0]        chr_din,
  output logic [7:0]        prg_rdata,
  output logic              prg_rvalid,
  output logic [7:0]        chr_rdata,
  output logic              chr_rvalid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              overflow
);

  // Memory handshake: mem_req rises with addr/we/wdata and all four stay stable
  // until the single-cycle mem_ack; mem_req then drops for at least one cycle.
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam logic [2:0] LP_STARVE = 3'(STARVE_LIMIT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_grant;
  logic              w_grant_chr;
  logic              w_done;

  logic              r_prg_pend;
  logic [ADDR_W-1:0] r_prg_addr;
  logic              r_prg_we;
  logic [7:0]        r_prg_data;
  logic              r_chr_pend;
  logic [ADDR_W-1:0] r_chr_addr;
  logic              r_chr_we;
  logic [7:0]        r_chr_data;
  logic              r_gnt_chr;
  logic [2:0]        r_starve;
  logic [7:0]        r_open_bus;

  logic w_prg_wr, w_prg_rd, w_prg_mem, w_prg_map, w_prg_open;
  logic w_prg_done, w_prg_full, w_prg_take, w_prg_ovf;
  logic w_chr_wr, w_chr_rd, w_chr_mem;
  logic w_chr_done, w_chr_full, w_chr_take, w_chr_ovf;
  logic w_mem_rd_done;

  // A write strobe masks a simultaneous read on the same side.
  assign w_prg_wr   = prg_write;
  assign w_prg_rd   = prg_read & ~prg_write;
  assign w_prg_mem  = (w_prg_wr & prg_allow) | (w_prg_rd & prg_allow & ~prg_bus_write);
  assign w_prg_map  = w_prg_rd & prg_bus_write;
  assign w_prg_open = w_prg_rd & ~prg_allow & ~prg_bus_write;

  assign w_chr_wr   = chr_write;
  assign w_chr_rd   = chr_read & ~chr_write;
  assign w_chr_mem  = (w_chr_wr & chr_allow) | w_chr_rd;

  assign w_prg_done = w_done & ~r_gnt_chr;
  assign w_chr_done = w_done &  r_gnt_chr;
  assign w_prg_full = r_prg_pend & ~w_prg_done;
  assign w_chr_full = r_chr_pend & ~w_chr_done;
  assign w_prg_take = w_prg_mem & ~w_prg_full;
  assign w_chr_take = w_chr_mem & ~w_chr_full;
  assign w_prg_ovf  = w_prg_mem &  w_prg_full;
  assign w_chr_ovf  = w_chr_mem &  w_chr_full;

  assign w_mem_rd_done = w_done & ~mem_we;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_chr = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_prg_pend || r_chr_pend) begin
          w_grant     = 1'b1;
          w_grant_chr = r_chr_pend && !(r_prg_pend && (r_starve == LP_STARVE));
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prg_pend <= 1'b0;
      r_prg_addr <= '0;
      r_prg_we   <= 1'b0;
      r_prg_data <= 8'h00;
      r_chr_pend <= 1'b0;
      r_chr_addr <= '0;
      r_chr_we   <= 1'b0;
      r_chr_data <= 8'h00;
      r_gnt_chr  <= 1'b0;
      r_starve   <= 3'd0;
      r_open_bus <= 8'hFF;
      prg_rdata  <= 8'h00;
      prg_rvalid <= 1'b0;
      chr_rdata  <= 8'h00;
      chr_rvalid <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      overflow   <= 1'b0;
    end else begin
      prg_rvalid <= 1'b0;
      chr_rvalid <= 1'b0;

      if (w_prg_take) begin
        r_prg_pend <= 1'b1;
        r_prg_addr <= prg_aout;
        r_prg_we   <= w_prg_wr;
        r_prg_data <= prg_din;
      end else if (w_prg_done) begin
        r_prg_pend <= 1'b0;
      end

      if (w_chr_take) begin
        r_chr_pend <= 1'b1;
        r_chr_addr <= chr_aout;
        r_chr_we   <= w_chr_wr;
        r_chr_data <= chr_din;
      end else if (w_chr_done) begin
        r_chr_pend <= 1'b0;
      end

      if (w_prg_ovf || w_chr_ovf) overflow <= 1'b1;

      if (!r_prg_pend)                r_starve <= 3'd0;
      else if (w_grant && !w_grant_chr) r_starve <= 3'd0;
      else if (w_grant)               r_starve <= r_starve + 3'd1;

      if (w_grant) begin
        mem_req   <= 1'b1;
        r_gnt_chr <= w_grant_chr;
        mem_addr  <= w_grant_chr ? r_chr_addr : r_prg_addr;
        mem_we    <= w_grant_chr ? r_chr_we   : r_prg_we;
        mem_wdata <= w_grant_chr ? r_chr_data : r_prg_data;
      end else if (w_done) begin
        mem_req <= 1'b0;
      end

      if (w_mem_rd_done) begin
        if (r_gnt_chr) begin
          chr_rdata  <= mem_rdata;
          chr_rvalid <= 1'b1;
        end else begin
          prg_rdata  <= mem_rdata;
          prg_rvalid <= 1'b1;
          r_open_bus <= mem_rdata;
        end
      end

      // A completing memory read owns the PRG return slot for this cycle.
      if (w_prg_map) begin
        r_open_bus <= map_prg_dout;
        if (!(w_mem_rd_done && !r_gnt_chr)) begin
          prg_rdata  <= map_prg_dout;
          prg_rvalid <= 1'b1;
        end
      end else if (w_prg_open && !(w_mem_rd_done && !r_gnt_chr)) begin
        prg_rdata  <= r_open_bus;
        prg_rvalid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nes_cart_mem_arbiter.sv
// Randomized and directed bench: per-side request/response queues model the arbiter,
// a memory responder checks requests, and a monitor checks every rvalid pulse.
module tb_nes_cart_mem_arbiter;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic          prg_read, prg_write, prg_allow, prg_bus_write;
  logic [AW-1:0] prg_aout;
  logic [7:0]    prg_din, map_prg_dout;
  logic          chr_read, chr_write, chr_allow;
  logic [AW-1:0] chr_aout;
  logic [7:0]    chr_din;
  logic [7:0]    prg_rdata, chr_rdata;
  logic          prg_rvalid, chr_rvalid;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          overflow;

  nes_cart_mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(2)) dut (
    .clk(clk), .reset(reset),
    .prg_read(prg_read), .prg_write(prg_write), .prg_aout(prg_aout), .prg_allow(prg_allow),
    .prg_din(prg_din), .prg_bus_write(prg_bus_write), .map_prg_dout(map_prg_dout),
    .chr_read(chr_read), .chr_write(chr_write), .chr_aout(chr_aout), .chr_allow(chr_allow),
    .chr_din(chr_din),
    .prg_rdata(prg_rdata), .prg_rvalid(prg_rvalid), .chr_rdata(chr_rdata), .chr_rvalid(chr_rvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [AW+8:0] exp_prg_mem_q[$];   // {we, addr, data}
  logic [AW+8:0] exp_chr_mem_q[$];
  logic [7:0]    exp_prg_rd_q[$];
  logic [7:0]    exp_chr_rd_q[$];
  logic          grant_log[$];       // 1 = CHR grant, 0 = PRG grant
  logic [7:0]    mdl_open_bus = 8'hFF;
  int            prg_out = 0;
  int            chr_out = 0;

  int   resp_delay       = -1;
  int   resp_rdata_fixed = -1;
  logic resp_en          = 1'b1;
  logic resp_cur_chr     = 1'b0;
  logic late_ack_req     = 1'b0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic ent_match(input logic [AW+8:0] e, input logic w,
                                     input logic [AW-1:0] a, input logic [7:0] d);
    return (e[AW+8] == w) && (e[AW+7:8] == a) && (!w || (e[7:0] == d));
  endfunction

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  task automatic serve_request();
    logic [AW-1:0] a;
    logic          w, is_chr, matched;
    logic [7:0]    d, rd;
    int            dly;
    a = mem_addr; w = mem_we; d = mem_wdata;
    is_chr = 1'b0; matched = 1'b0;
    if (exp_chr_mem_q.size() > 0 && ent_match(exp_chr_mem_q[0], w, a, d)) begin
      is_chr = 1'b1; matched = 1'b1; void'(exp_chr_mem_q.pop_front());
    end else if (exp_prg_mem_q.size() > 0 && ent_match(exp_prg_mem_q[0], w, a, d)) begin
      matched = 1'b1; void'(exp_prg_mem_q.pop_front());
    end
    checks++;
    if (!matched) begin
      failures++;
      $display("FAIL mem_req_match got we=%0d addr=%0h wdata=%0h exp=no such pending request", w, a, d);
    end else begin
      grant_log.push_back(is_chr);
    end
    resp_cur_chr = is_chr;
    dly = (resp_delay >= 0) ? resp_delay : $urandom_range(0, 3);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check1("mem_hold", {mem_req, mem_we, mem_wdata, mem_addr[21:0]}, {1'b1, w, d, a[21:0]});
    end
    rd = (resp_rdata_fixed >= 0) ? 8'(resp_rdata_fixed) : 8'($urandom);
    mem_ack = 1'b1;
    mem_rdata = rd;
    if (matched && !w) begin
      if (is_chr) exp_chr_rd_q.push_back(rd);
      else begin exp_prg_rd_q.push_back(rd); mdl_open_bus = rd; end
    end
    if (matched && w) begin
      if (is_chr) chr_out--; else prg_out--;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    check1("mem_req_turnaround", {31'd0, mem_req}, 32'd0);
    if (matched && !w)
      check1("rvalid_after_ack", {31'd0, is_chr ? chr_rvalid : prg_rvalid}, 32'd1);
  endtask

  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!resp_en) begin
        if (late_ack_req) begin
          mem_ack = 1'b1;
          mem_rdata = 8'h5C;
          late_ack_req = 1'b0;
        end
      end else if (mem_req === 1'b1 && reset === 1'b0) begin
        serve_request();
      end
    end
  end

  // ---------------- rvalid monitor ----------------
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (prg_rvalid === 1'b1) begin
        checks++;
        if (exp_prg_rd_q.size() == 0) begin
          failures++;
          $display("FAIL prg_rvalid_unexpected got=%0h exp=no pulse", prg_rdata);
        end else begin
          e = exp_prg_rd_q.pop_front();
          if (prg_rdata !== e) begin
            failures++;
            $display("FAIL prg_rdata got=%0h exp=%0h", prg_rdata, e);
          end
          if (prg_out > 0) prg_out--;
        end
      end
      if (chr_rvalid === 1'b1) begin
        checks++;
        if (exp_chr_rd_q.size() == 0) begin
          failures++;
          $display("FAIL chr_rvalid_unexpected got=%0h exp=no pulse", chr_rdata);
        end else begin
          e = exp_chr_rd_q.pop_front();
          if (chr_rdata !== e) begin
            failures++;
            $display("FAIL chr_rdata got=%0h exp=%0h", chr_rdata, e);
          end
          if (chr_out > 0) chr_out--;
        end
      end
    end
  end

  // ---------------- drivers (called at negedge+1) ----------------
  // PRG kinds: 0 mem read, 1 mem write, 2 mapper read, 3 disallowed read,
  //            4 disallowed write, 5 read+write together (write wins)
  task automatic prg_op(input int kind, input logic [AW-1:0] a, input logic [7:0] d, input logic [7:0] m);
    prg_aout = a; prg_din = d; map_prg_dout = m;
    prg_read      = (kind == 0 || kind == 2 || kind == 3 || kind == 5);
    prg_write     = (kind == 1 || kind == 4 || kind == 5);
    prg_bus_write = (kind == 2);
    prg_allow     = (kind == 2) ? 1'($urandom_range(0, 1)) : !(kind == 3 || kind == 4);
    case (kind)
      0:    begin exp_prg_mem_q.push_back({1'b0, a, d}); prg_out++; end
      1, 5: begin exp_prg_mem_q.push_back({1'b1, a, d}); prg_out++; end
      2:    begin exp_prg_rd_q.push_back(m); mdl_open_bus = m; prg_out++; end
      3:    begin exp_prg_rd_q.push_back(mdl_open_bus); prg_out++; end
      default: ;
    endcase
    tick();
    prg_read = 1'b0; prg_write = 1'b0;
  endtask

  // CHR kinds: 0 read (allow ignored), 1 allowed write, 2 disallowed write, 3 read+write
  task automatic chr_op(input int kind, input logic [AW-1:0] a, input logic [7:0] d);
    chr_aout = a; chr_din = d;
    chr_read  = (kind == 0 || kind == 3);
    chr_write = (kind != 0);
    chr_allow = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind != 2);
    case (kind)
      0:    begin exp_chr_mem_q.push_back({1'b0, a, d}); chr_out++; end
      1, 3: begin exp_chr_mem_q.push_back({1'b1, a, d}); chr_out++; end
      default: ;
    endcase
    tick();
    chr_read = 1'b0; chr_write = 1'b0;
  endtask

  task automatic wait_prg_idle();
    int n = 0;
    while (prg_out != 0 && n < 300) begin tick(); n++; end
    if (prg_out != 0) begin
      checks++; failures++;
      $display("FAIL prg_idle_timeout got=%0d outstanding exp=0", prg_out);
      prg_out = 0;
    end
  endtask

  task automatic wait_chr_idle();
    int n = 0;
    while (chr_out != 0 && n < 300) begin tick(); n++; end
    if (chr_out != 0) begin
      checks++; failures++;
      $display("FAIL chr_idle_timeout got=%0d outstanding exp=0", chr_out);
      chr_out = 0;
    end
  endtask

  task automatic wait_mem_req();
    int n = 0;
    while (mem_req !== 1'b1 && n < 50) begin tick(); n++; end
    check1("mem_req_seen", {31'd0, mem_req}, 32'd1);
  endtask

  function automatic logic [AW-1:0] rand_prg_addr();
    return AW'($urandom_range(0, 22'h1FFFFF));
  endfunction

  function automatic logic [AW-1:0] rand_chr_addr();
    return AW'(22'h200000 | $urandom_range(0, 22'h1FFFFF));
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    reset = 1'b1;
    prg_read = 0; prg_write = 0; prg_allow = 0; prg_bus_write = 0;
    prg_aout = '0; prg_din = 0; map_prg_dout = 0;
    chr_read = 0; chr_write = 0; chr_allow = 0; chr_aout = '0; chr_din = 0;
    repeat (3) tick();
    check1("reset_outputs",
           {prg_rdata, chr_rdata, mem_wdata, 4'd0, prg_rvalid, chr_rvalid, mem_req, mem_we},
           32'd0);
    check1("reset_addr_ovf", {9'd0, mem_addr, overflow}, 32'd0);
    reset = 1'b0;
    tick();

    // open-bus latch starts at FF
    prg_op(3, 22'h001000, 8'h00, 8'h00);
    wait_prg_idle();

    // PRG read with a fixed 2-cycle hold and known data
    resp_delay = 2; resp_rdata_fixed = 8'hA5;
    prg_op(0, 22'h008123, 8'h00, 8'h00);
    wait_prg_idle();
    resp_delay = -1; resp_rdata_fixed = -1;

    // mapper-driven read, then open-bus repeat of its value
    grant_log.delete();
    prg_op(2, 22'h00C000, 8'h00, 8'h3A);
    tick(); tick();
    check1("mapper_read_no_req", {31'd0, mem_req}, 32'd0);
    wait_prg_idle();
    prg_op(3, 22'h00D000, 8'h00, 8'h00);
    wait_prg_idle();
    check1("mapper_read_grants", grant_log.size(), 32'd0);

    // simultaneous reads: CHR served first
    grant_log.delete();
    fork
      prg_op(0, 22'h004444, 8'h00, 8'h00);
      chr_op(0, 22'h201234, 8'h00);
    join
    wait_prg_idle(); wait_chr_idle();
    checks++;
    if (grant_log.size() != 2 || grant_log[0] !== 1'b1 || grant_log[1] !== 1'b0) begin
      failures++;
      $display("FAIL grant_order_simul got=%0d grants first=%0d exp=CHR then PRG",
               grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 1'bx);
    end

    // starvation bound: CHR re-strobed on every CHR ack while PRG waits
    grant_log.delete();
    resp_delay = 1;
    fork
      prg_op(0, 22'h006000, 8'h00, 8'h00);
      chr_op(0, 22'h210000, 8'h00);
    join
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!(mem_ack === 1'b1 && resp_cur_chr) && n < 100) begin tick(); n++; end
      check1("starve_chr_ack_seen", {31'd0, mem_ack}, 32'd1);
      chr_op(0, AW'(22'h210001 + k), 8'h00);
    end
    wait_prg_idle(); wait_chr_idle();
    resp_delay = -1;
    checks++;
    if (grant_log.size() < 3 || grant_log[0] !== 1'b1 || grant_log[1] !== 1'b1 || grant_log[2] !== 1'b0) begin
      failures++;
      $display("FAIL grant_order_starve got=%0d grants exp=CHR,CHR,PRG", grant_log.size());
    end

    // randomized traffic on both sides
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          wait_prg_idle();
          repeat ($urandom_range(0, 2)) tick();
          prg_op($urandom_range(0, 5), rand_prg_addr(), 8'($urandom), 8'($urandom));
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          wait_chr_idle();
          repeat ($urandom_range(0, 2)) tick();
          chr_op($urandom_range(0, 3), rand_chr_addr(), 8'($urandom));
        end
      end
    join
    wait_prg_idle(); wait_chr_idle();
    tick(); tick();
    check1("no_overflow_random", {31'd0, overflow}, 32'd0);

    // disallowed CHR write never reaches memory
    grant_log.delete();
    chr_op(2, 22'h230000, 8'h77);
    repeat (5) tick();
    check1("chr_write_blocked", {31'd0, mem_req}, 32'd0);
    check1("chr_write_blocked_grants", grant_log.size(), 32'd0);

    // second CHR strobe while slot busy
    grant_log.delete();
    resp_delay = 3;
    chr_op(0, 22'h240000, 8'h00);
    wait_mem_req();
    chr_aout = 22'h240001; chr_read = 1'b1; chr_allow = 1'b1;
    tick();
    chr_read = 1'b0;
    tick();
    check1("overflow_set", {31'd0, overflow}, 32'd1);
    wait_chr_idle();
    repeat (3) tick();
    check1("overflow_sticky", {31'd0, overflow}, 32'd1);
    check1("overflow_single_req", grant_log.size(), 32'd1);
    resp_delay = -1;

    // reset while BUSY, then a stale ack
    resp_en = 1'b0;
    chr_op(0, 22'h250000, 8'h00);
    wait_mem_req();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("reset_busy_req_drop", {31'd0, mem_req}, 32'd0);
    check1("reset_clears_overflow", {31'd0, overflow}, 32'd0);
    exp_chr_mem_q.delete(); exp_prg_mem_q.delete();
    exp_chr_rd_q.delete();  exp_prg_rd_q.delete();
    chr_out = 0; prg_out = 0; mdl_open_bus = 8'hFF;
    late_ack_req = 1'b1;
    repeat (5) tick();
    check1("late_ack_ignored", {30'd0, mem_req, chr_rvalid}, 32'd0);
    resp_en = 1'b1;
    prg_op(3, 22'h001234, 8'h00, 8'h00);
    wait_prg_idle();
    repeat (3) tick();

    checks++;
    if (exp_prg_mem_q.size() + exp_chr_mem_q.size() + exp_prg_rd_q.size() + exp_chr_rd_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got=%0d entries exp=0",
               exp_prg_mem_q.size() + exp_chr_mem_q.size() + exp_prg_rd_q.size() + exp_chr_rd_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
